// File: rtl/spw_fifo_pkg.sv
// Shared constants and helpers for the SpaceWire receive N-char buffer controller.
package spw_fifo_pkg;

    localparam int unsigned FCT_CREDIT = 8;
    localparam int unsigned MAX_CREDIT = 56;
    localparam int unsigned CREDIT_W   = 6;
    localparam int unsigned PTR_W_MAX  = 16;

    // Modular distance head - tail over an aw-bit pointer space.
    function automatic logic [PTR_W_MAX-1:0] ptr_dist(
        input logic [PTR_W_MAX-1:0] head,
        input logic [PTR_W_MAX-1:0] tail,
        input int unsigned          aw
    );
        logic [PTR_W_MAX-1:0] mask;
        mask = (PTR_W_MAX'(1) << aw) - PTR_W_MAX'(1);
        return (head - tail) & mask;
    endfunction

endpackage

// File: rtl/spw_credit_cnt.sv
// Outstanding-credit counter, FCT request generation and credit-error flag.
module spw_credit_cnt
    import spw_fifo_pkg::*;
#(
    parameter int unsigned AWIDTH     = 6,
    parameter int unsigned FCT_CRED   = FCT_CREDIT,
    parameter int unsigned MAX_CRED   = MAX_CREDIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_wr_en,
    input  logic                i_push,
    input  logic                i_fct_ack,
    input  logic [AWIDTH-1:0]   i_free,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_fct_req,
    output logic                o_credit_err
);

    localparam int unsigned CMP_W = ((AWIDTH > CREDIT_W) ? AWIDTH : CREDIT_W) + 2;

    logic [CREDIT_W-1:0] r_credit;
    logic                r_fct_req;
    logic                r_credit_err;

    logic                w_ack;
    logic                w_set;
    logic                w_req_next;
    logic [CREDIT_W-1:0] w_credit_next;
    logic [CMP_W-1:0]    w_credit_ext;
    logic [CMP_W-1:0]    w_free_ext;

    // Request another FCT only if the credit ceiling and free space both allow it.
    always_comb begin
        w_credit_ext  = CMP_W'(r_credit);
        w_free_ext    = CMP_W'(i_free);
        w_ack         = i_fct_ack & r_fct_req;
        w_set         = ~r_fct_req
                      & (w_credit_ext <= CMP_W'(MAX_CRED - FCT_CRED))
                      & (w_free_ext >= (w_credit_ext + CMP_W'(FCT_CRED)));
        w_credit_next = r_credit
                      + (w_ack ? CREDIT_W'(FCT_CRED) : CREDIT_W'(0))
                      - CREDIT_W'(i_push);
        w_req_next    = r_fct_req;
        if (w_ack) begin
            w_req_next = 1'b0;
        end else if (w_set) begin
            w_req_next = 1'b1;
        end
    end

    // Credit, request and error registers; link clear dominates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_credit     <= '0;
            r_fct_req    <= 1'b0;
            r_credit_err <= 1'b0;
        end else if (i_clr) begin
            r_credit     <= '0;
            r_fct_req    <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_credit     <= w_credit_next;
            r_fct_req    <= w_req_next;
            r_credit_err <= i_wr_en & (r_credit == '0);
        end
    end

    assign o_credit     = r_credit;
    assign o_fct_req    = r_fct_req;
    assign o_credit_err = r_credit_err;

endmodule

// File: rtl/spw_rx_fifo_ctrl.sv
// Pointer and handshake controller for the SpaceWire receive N-char buffer.
module spw_rx_fifo_ctrl
    import spw_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH     = 9,
    parameter int unsigned AWIDTH     = 6,
    parameter int unsigned FCT_CRED   = FCT_CREDIT,
    parameter int unsigned MAX_CRED   = MAX_CREDIT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_link_clr,
    input  logic                i_wr_en,
    input  logic [DWIDTH-1:0]   i_wr_data,
    input  logic                i_rd_en,
    output logic [DWIDTH-1:0]   o_rd_data,
    output logic                o_rd_valid,
    output logic [DWIDTH-1:0]   o_mem_data_in,
    output logic [AWIDTH-1:0]   o_mem_wr_ptr,
    output logic [AWIDTH-1:0]   o_mem_rd_ptr,
    input  logic [DWIDTH-1:0]   i_mem_data_out,
    output logic                o_fct_req,
    input  logic                i_fct_ack,
    output logic                o_credit_err,
    output logic [AWIDTH-1:0]   o_count,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam int unsigned CAPACITY = (1 << AWIDTH) - 1;

    logic [AWIDTH-1:0]   r_wr_ptr;
    logic [AWIDTH-1:0]   r_wr_ptr_d;
    logic [AWIDTH-1:0]   r_rd_ptr;

    logic [AWIDTH-1:0]   w_rd_ptr_next;
    logic [AWIDTH-1:0]   w_count;
    logic [AWIDTH-1:0]   w_free;
    logic [CREDIT_W-1:0] w_credit;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_rd_valid;

    // Occupancy, accept conditions and next read pointer.
    always_comb begin
        w_count       = AWIDTH'(ptr_dist(PTR_W_MAX'(r_wr_ptr), PTR_W_MAX'(r_rd_ptr), AWIDTH));
        w_free        = AWIDTH'(CAPACITY) - w_count;
        w_full        = (r_wr_ptr + AWIDTH'(1)) == r_rd_ptr;
        w_push        = i_wr_en & (w_credit != '0) & ~w_full;
        // Delayed write pointer hides a slot until the memory has actually written it.
        w_rd_valid    = r_wr_ptr_d != r_rd_ptr;
        w_pop         = i_rd_en & w_rd_valid;
        w_rd_ptr_next = r_rd_ptr + AWIDTH'(w_pop);
    end

    // Pointer registers; link clear dominates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_d <= '0;
            r_rd_ptr   <= '0;
        end else if (i_link_clr) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_d <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AWIDTH'(w_push);
            r_wr_ptr_d <= r_wr_ptr;
            r_rd_ptr   <= w_rd_ptr_next;
        end
    end

    spw_credit_cnt #(
        .AWIDTH   (AWIDTH),
        .FCT_CRED (FCT_CRED),
        .MAX_CRED (MAX_CRED)
    ) u_credit (
        .clock        (clock),
        .reset        (reset),
        .i_clr        (i_link_clr),
        .i_wr_en      (i_wr_en),
        .i_push       (w_push),
        .i_fct_ack    (i_fct_ack),
        .i_free       (w_free),
        .o_credit     (w_credit),
        .o_fct_req    (o_fct_req),
        .o_credit_err (o_credit_err)
    );

    // Memory-facing read address is the look-ahead pointer so the head reloads on a pop.
    assign o_rd_data     = i_mem_data_out;
    assign o_rd_valid    = w_rd_valid;
    assign o_mem_data_in = i_wr_data;
    assign o_mem_wr_ptr  = r_wr_ptr;
    assign o_mem_rd_ptr  = w_rd_ptr_next;
    assign o_count       = w_count;
    assign o_credit      = w_credit;

endmodule

// File: tb/tb_spw_rx_fifo_ctrl.sv
// Scoreboard bench for spw_rx_fifo_ctrl with a write-every-cycle, registered-read memory model.
module tb_spw_rx_fifo_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       i_link_clr;
    logic       i_wr_en;
    logic [8:0] i_wr_data;
    logic       i_rd_en;
    logic [8:0] o_rd_data;
    logic       o_rd_valid;
    logic [8:0] o_mem_data_in;
    logic [5:0] o_mem_wr_ptr;
    logic [5:0] o_mem_rd_ptr;
    logic [8:0] i_mem_data_out;
    logic       o_fct_req;
    logic       i_fct_ack;
    logic       o_credit_err;
    logic [5:0] o_count;
    logic [5:0] o_credit;

    logic [8:0] mem [0:63];
    logic [8:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_credit = 0;
    int         m_count = 0;

    always #5 clock = ~clock;

    // Memory model: writes the slot at wr_ptr every cycle, registered read-before-write.
    always @(posedge clock) begin
        mem[o_mem_wr_ptr] <= o_mem_data_in;
        i_mem_data_out    <= mem[o_mem_rd_ptr];
    end

    spw_rx_fifo_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .i_link_clr     (i_link_clr),
        .i_wr_en        (i_wr_en),
        .i_wr_data      (i_wr_data),
        .i_rd_en        (i_rd_en),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_mem_data_in  (o_mem_data_in),
        .o_mem_wr_ptr   (o_mem_wr_ptr),
        .o_mem_rd_ptr   (o_mem_rd_ptr),
        .i_mem_data_out (i_mem_data_out),
        .o_fct_req      (o_fct_req),
        .i_fct_ack      (i_fct_ack),
        .o_credit_err   (o_credit_err),
        .o_count        (o_count),
        .o_credit       (o_credit)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted read and checks the credit invariant.
    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (o_rd_valid && i_rd_en) begin
                    if (exp_q.size() == 0) begin
                        check("pop_with_empty_scoreboard", int'(o_rd_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", int'(o_rd_data), int'(e));
                    end
                end
                check("inv_credit_le_free", int'(int'(o_credit) <= 63 - int'(o_count)), 1);
                check("inv_credit_le_56", int'(int'(o_credit) <= 56), 1);
            end
        end
    endtask

    task automatic wait_req();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_fct_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("fct_req_wait", int'(seen), 1);
    endtask

    task automatic do_ack();
        wait_req();
        i_fct_ack = 1'b1;
        tick();
        i_fct_ack = 1'b0;
        m_credit += 8;
        check("ack_credit", int'(o_credit), m_credit);
        check("ack_req_clr", int'(o_fct_req), 0);
    endtask

    task automatic push_burst(input int n, input int seed);
        logic [8:0] d;
        for (int k = 0; k < n; k++) begin
            d = 9'(seed + k * 37);
            d[8] = k[0];
            i_wr_en   = 1'b1;
            i_wr_data = d;
            exp_q.push_back(d);
            m_credit--;
            m_count++;
            tick();
        end
        i_wr_en = 1'b0;
    endtask

    task automatic pop_burst(input int n);
        int bubbles;
        bubbles = 0;
        i_rd_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (!o_rd_valid) bubbles++;
            tick();
        end
        i_rd_en = 1'b0;
        m_count -= n;
        check("pop_bubbles", bubbles, 0);
    endtask

    initial begin
        reset      = 1'b0;
        i_link_clr = 1'b0;
        i_wr_en    = 1'b0;
        i_wr_data  = '0;
        i_rd_en    = 1'b0;
        i_fct_ack  = 1'b0;
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_count", int'(o_count), 0);
        check("rst_credit", int'(o_credit), 0);
        check("rst_fct_req", int'(o_fct_req), 0);
        check("rst_rd_valid", int'(o_rd_valid), 0);
        check("rst_credit_err", int'(o_credit_err), 0);
        reset = 1'b1;
        tick();
        check("post_rst_fct_req", int'(o_fct_req), 1);

        // Ack up to the 56-credit ceiling
        for (int a = 0; a < 7; a++) do_ack();
        repeat (3) tick();
        check("ceiling_no_req", int'(o_fct_req), 0);
        check("ceiling_credit", int'(o_credit), 56);

        // Full-credit burst, first pass
        push_burst(56, 5);
        check("burst1_count", int'(o_count), 56);
        check("burst1_credit", int'(o_credit), 0);
        check("burst1_wr_ptr", int'(o_mem_wr_ptr), 56);
        pop_burst(56);
        check("burst1_drained", int'(o_count), 0);
        check("burst1_rd_ptr", int'(o_mem_rd_ptr), 56);

        // Second pass wraps both pointers through 63 -> 0
        for (int a = 0; a < 7; a++) do_ack();
        push_burst(56, 200);
        check("burst2_count", int'(o_count), 56);
        check("burst2_wr_ptr", int'(o_mem_wr_ptr), 48);
        pop_burst(56);
        check("burst2_drained", int'(o_count), 0);
        check("burst2_rd_ptr", int'(o_mem_rd_ptr), 48);

        // rd_en while empty is ignored
        i_rd_en = 1'b1;
        #1;
        check("rd_ign_ptr_next", int'(o_mem_rd_ptr), 48);
        tick();
        i_rd_en = 1'b0;
        #1;
        check("rd_ign_rd_ptr", int'(o_mem_rd_ptr), 48);

        // Push with zero credit is dropped and flagged
        i_wr_en   = 1'b1;
        i_wr_data = 9'h055;
        tick();
        i_wr_en = 1'b0;
        check("cerr_pulse", int'(o_credit_err), 1);
        check("cerr_count", int'(o_count), 0);
        check("cerr_wr_ptr", int'(o_mem_wr_ptr), 48);
        tick();
        check("cerr_single", int'(o_credit_err), 0);

        // Single push latency with credit 8
        do_ack();
        i_wr_en   = 1'b1;
        i_wr_data = 9'h1A5;
        exp_q.push_back(9'h1A5);
        m_credit--;
        m_count++;
        tick();
        i_wr_en = 1'b0;
        check("lat_t1_rd_valid", int'(o_rd_valid), 0);
        check("lat_t1_credit", int'(o_credit), 7);
        check("lat_t1_count", int'(o_count), 1);
        tick();
        check("lat_t2_rd_valid", int'(o_rd_valid), 1);
        check("lat_t2_rd_data", int'(o_rd_data), 'h1A5);
        pop_burst(1);
        check("lat_drained", int'(o_count), 0);

        // Push and ack in the same cycle at credit 1
        push_burst(6, 77);
        check("c1_credit", int'(o_credit), 1);
        wait_req();
        i_wr_en   = 1'b1;
        i_wr_data = 9'h0F3;
        i_fct_ack = 1'b1;
        exp_q.push_back(9'h0F3);
        tick();
        i_wr_en   = 1'b0;
        i_fct_ack = 1'b0;
        m_credit  = m_credit - 1 + 8;
        m_count++;
        check("push_ack_credit", int'(o_credit), 8);
        pop_burst(2);
        check("pp_count_start", int'(o_count), 5);

        // Simultaneous push and pop at count 5
        for (int k = 0; k < 4; k++) begin
            i_wr_en   = 1'b1;
            i_wr_data = 9'(9'h140 + k * 3);
            i_rd_en   = 1'b1;
            exp_q.push_back(i_wr_data);
            m_credit--;
            tick();
            check("pp_count", int'(o_count), 5);
        end
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        check("pp_credit", int'(o_credit), m_credit);
        pop_burst(5);
        check("pp_drained", int'(o_count), 0);
        check("sb_empty", exp_q.size(), 0);

        // Link clear mid-stream at count 20, credit 30, fct_req 1
        for (int a = 0; a < 6; a++) do_ack();
        push_burst(22, 11);
        pop_burst(2);
        wait_req();
        check("clr_pre_count", int'(o_count), 20);
        check("clr_pre_credit", int'(o_credit), 30);
        check("clr_pre_req", int'(o_fct_req), 1);
        i_link_clr = 1'b1;
        tick();
        i_link_clr = 1'b0;
        exp_q.delete();
        m_credit = 0;
        m_count  = 0;
        check("clr_count", int'(o_count), 0);
        check("clr_credit", int'(o_credit), 0);
        check("clr_req", int'(o_fct_req), 0);
        check("clr_rd_valid", int'(o_rd_valid), 0);
        tick();
        check("clr_req_reassert", int'(o_fct_req), 1);
        check("clr_rd_valid_hold", int'(o_rd_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spw_rx_fifo_ctrl.md
Name: spw_rx_fifo_ctrl

Overview:
- Pointer, flow-control and handshake controller for the receive-side N-char buffer (mem_data, 9-bit entries, 2**AWIDTH deep) in the SpaceWire link.
- Turns decoder push requests into write-pointer advances and host pop requests into read-pointer advances.
- Tracks occupancy and generates FCT requests per ECSS-E-ST-50-12C: one FCT per 8 reserved free slots, at most 56 outstanding credits.
- Compensates for the memory's write-every-cycle and registered-read behaviour.

Parameters:
- DWIDTH, 9, N-char width (data byte + control flag); passed through to the memory.
- AWIDTH, 6, memory address width; usable capacity is 2**AWIDTH-1 entries.
- FCT_CREDIT, 8, credits granted per FCT.
- MAX_CREDIT, 56, maximum outstanding credits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low; clock clock
- link_clr  in  1  synchronous clear; link state machine has left Run
- wr_en  in  1  push strobe from rx decoder
- wr_data  in  DWIDTH  N-char to push
- rd_en  in  1  pop strobe from host; honoured only when rd_valid=1
- rd_data  out  DWIDTH  head N-char (combinational = mem_data_out)
- rd_valid  out  1  rd_data holds a valid head entry
- mem_data_in  out  DWIDTH  to memory data_in (combinational = wr_data)
- mem_wr_ptr  out  AWIDTH  to memory wr_ptr (= wr_ptr register)
- mem_rd_ptr  out  AWIDTH  to memory rd_ptr (= rd_ptr_next, combinational)
- mem_data_out  in  DWIDTH  from memory data_out
- fct_req  out  1  level request to tx to send one FCT
- fct_ack  in  1  tx has sent the FCT; single-cycle pulse
- credit_err  out  1  one-cycle pulse: push arrived with zero credit
- count  out  AWIDTH  committed entries (wr_ptr - rd_ptr mod 2**AWIDTH)
- credit  out  6  outstanding credits

Behaviour:
- Reset (async) or link_clr (sync, dominant over all other inputs that cycle): wr_ptr, wr_ptr_d, rd_ptr, credit = 0; fct_req, credit_err = 0. rd_valid = 0 from the following cycle. Memory contents are not cleared.
- The memory writes MEM[wr_ptr] every cycle, so the slot at wr_ptr must always be free. Full = (wr_ptr+1 == rd_ptr); capacity is 2**AWIDTH-1.
- Push accepted = wr_en & credit!=0 & !full: wr_ptr increments (wraps 63 to 0); credit decrements by 1.
- wr_en with credit==0: pushed data is dropped and credit_err pulses the next cycle. Full cannot occur while credit>0, because credit never exceeds free slots.
- wr_ptr_d <= wr_ptr every cycle.
- rd_valid = (wr_ptr_d != rd_ptr). An entry pushed in cycle t is valid in cycle t+2.
- Pop = rd_en & rd_valid. rd_ptr_next = rd_ptr + pop; rd_ptr <= rd_ptr_next.
  - The head is therefore reloaded on the same edge, giving back-to-back pops at one per cycle.
  - rd_en while rd_valid=0 is ignored.
- free = (2**AWIDTH-1) - count.
- fct_req sets (registered) when !fct_req & credit <= MAX_CREDIT-FCT_CREDIT & free >= credit+FCT_CREDIT.
- fct_ack while fct_req=1: credit += 8; fct_req clears in the same cycle. It may re-set at the earliest the cycle after.
- fct_ack while fct_req=0: ignored.
- Push + fct_ack in the same cycle: credit = credit + 7.
- Push + pop in the same cycle: count unchanged. The pop must not cause a re-read of a slot written in that cycle; wr_ptr_d guarantees this.
- Invariant: credit <= free and credit <= 56 at all times. The bench asserts this.

Decomposition:
- Package spw_fifo_pkg holds FCT_CREDIT, MAX_CREDIT, CREDIT_W=6 and a function for modular pointer distance.
- Natural sub-module spw_credit_cnt contains the credit register, the fct_req set/clear logic and credit_err.
- Pointer logic stays in the top level.

Test Plan:
- Post-reset idle, 1 cycle: fct_req=1, then ack → credit=8. Repeat acks until credit=56; fct_req then stays 0 (free=63, 56+8>63).
- Credit 8, push 0x1A5 at cycle t: rd_valid=0 at t+1, rd_valid=1 with rd_data=0x1A5 at t+2, credit=7, count=1.
- Credit 56, 56 consecutive pushes then 56 consecutive pops with rd_en held high: data in order, one per cycle, no bubbles. Pointers wrap 63→0 correctly on a second pass. count returns to 0.
- Credit 0, wr_en with 0x055: credit_err pulses 1 cycle, count stays 0, wr_ptr unchanged.
- Credit 1, push and fct_ack in the same cycle: credit=8 next cycle. Then simultaneous push/pop at count=5: count stays 5, data order preserved.
- link_clr mid-stream at count=20, credit=30, fct_req=1: next cycle count=0, credit=0, fct_req=0, rd_valid=0. Then fct_req re-asserts one cycle later.
